// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI byte engine between two master controllers,
// with per-device chip selects, locked bursts, a guard gap between owners and an idle timeout.
module spi_bus_arbiter #(
  parameter int GUARD_CYCLES = 4,
  parameter int TIMEOUT      = 65535
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       req0,
  input  logic       lock0,
  input  logic       begin0,
  input  logic [7:0] send_data0,
  output logic [7:0] recv_data0,
  output logic       end0,
  output logic       gnt0,
  input  logic       req1,
  input  logic       lock1,
  input  logic       begin1,
  input  logic [7:0] send_data1,
  output logic [7:0] recv_data1,
  output logic       end1,
  output logic       gnt1,
  output logic       spi_begin,
  output logic [7:0] spi_send_data,
  input  logic [7:0] spi_recv_data,
  input  logic       spi_end,
  output logic       spi_ss,
  output logic [1:0] cs_n,
  output logic       timeout_err
);

  typedef enum logic [2:0] {IDLE, OWN, XFER, HOLD, GUARD} state_t;

  localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYCLES - 1);
  localparam logic [15:0] IDLE_LAST  = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        ptr_q, ptr_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  cs_n_q, cs_n_d;
  logic        spi_begin_q, spi_begin_d;
  logic [7:0]  spi_send_data_q, spi_send_data_d;
  logic [7:0]  recv_data0_q, recv_data0_d;
  logic [7:0]  recv_data1_q, recv_data1_d;
  logic        end0_q, end0_d;
  logic        end1_q, end1_d;
  logic        timeout_err_q, timeout_err_d;
  logic [15:0] guard_cnt_q, guard_cnt_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;

  logic       own_req, own_lock, own_begin;
  logic [7:0] own_send;
  logic       sel, start, rel;

  always_comb begin
    own_req   = owner_q ? req1 : req0;
    own_lock  = owner_q ? lock1 : lock0;
    own_begin = owner_q ? begin1 : begin0;
    own_send  = owner_q ? send_data1 : send_data0;
    // Lone requester wins outright; on a tie the pointer decides.
    sel       = req1 & (~req0 | ptr_q);

    state_d         = state_q;
    owner_d         = owner_q;
    ptr_d           = ptr_q;
    gnt_d           = gnt_q;
    cs_n_d          = cs_n_q;
    spi_begin_d     = 1'b0;
    spi_send_data_d = spi_send_data_q;
    recv_data0_d    = recv_data0_q;
    recv_data1_d    = recv_data1_q;
    end0_d          = 1'b0;
    end1_d          = 1'b0;
    timeout_err_d   = 1'b0;
    guard_cnt_d     = guard_cnt_q;
    idle_cnt_d      = idle_cnt_q;
    start           = 1'b0;
    rel             = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          owner_d = sel;
          gnt_d   = sel ? 2'b10 : 2'b01;
          cs_n_d  = sel ? 2'b01 : 2'b10;
          state_d = OWN;
        end
      end
      OWN: begin
        if (own_begin)     start = 1'b1;
        else if (!own_req) rel   = 1'b1;
      end
      XFER: begin
        if (spi_end) begin
          if (owner_q) begin
            recv_data1_d = spi_recv_data;
            end1_d       = 1'b1;
          end else begin
            recv_data0_d = spi_recv_data;
            end0_d       = 1'b1;
          end
          if (own_lock) begin
            state_d    = HOLD;
            idle_cnt_d = 16'd0;
          end else begin
            rel = 1'b1;
          end
        end
      end
      HOLD: begin
        if (own_begin) begin
          start = 1'b1;
        end else if (!own_lock || !own_req) begin
          rel = 1'b1;
        end else if (idle_cnt_q == IDLE_LAST) begin
          rel           = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
      end
      GUARD: begin
        if (guard_cnt_q == GUARD_LAST) state_d = IDLE;
        else                           guard_cnt_d = guard_cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d         = XFER;
      spi_begin_d     = 1'b1;
      spi_send_data_d = own_send;
      idle_cnt_d      = 16'd0;
    end
    // Release hands the next tie to the other requester.
    if (rel) begin
      state_d     = GUARD;
      gnt_d       = 2'b00;
      cs_n_d      = 2'b11;
      ptr_d       = ~owner_q;
      guard_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q         <= IDLE;
      owner_q         <= 1'b0;
      ptr_q           <= 1'b0;
      gnt_q           <= 2'b00;
      cs_n_q          <= 2'b11;
      spi_begin_q     <= 1'b0;
      spi_send_data_q <= 8'h00;
      recv_data0_q    <= 8'h00;
      recv_data1_q    <= 8'h00;
      end0_q          <= 1'b0;
      end1_q          <= 1'b0;
      timeout_err_q   <= 1'b0;
      guard_cnt_q     <= 16'd0;
      idle_cnt_q      <= 16'd0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      ptr_q           <= ptr_d;
      gnt_q           <= gnt_d;
      cs_n_q          <= cs_n_d;
      spi_begin_q     <= spi_begin_d;
      spi_send_data_q <= spi_send_data_d;
      recv_data0_q    <= recv_data0_d;
      recv_data1_q    <= recv_data1_d;
      end0_q          <= end0_d;
      end1_q          <= end1_d;
      timeout_err_q   <= timeout_err_d;
      guard_cnt_q     <= guard_cnt_d;
      idle_cnt_q      <= idle_cnt_d;
    end
  end

  assign gnt0          = gnt_q[0];
  assign gnt1          = gnt_q[1];
  assign cs_n          = cs_n_q;
  assign spi_ss        = &cs_n_q;
  assign spi_begin     = spi_begin_q;
  assign spi_send_data = spi_send_data_q;
  assign recv_data0    = recv_data0_q;
  assign recv_data1    = recv_data1_q;
  assign end0          = end0_q;
  assign end1          = end1_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: per-cycle vector table plus directed burst, timeout and reset sequences.
module tb_spi_bus_arbiter;

  logic       clk = 1'b0;
  logic       RST = 1'b0;
  logic       req0 = 1'b0, lock0 = 1'b0, begin0 = 1'b0;
  logic [7:0] send_data0 = 8'h00;
  logic       req1 = 1'b0, lock1 = 1'b0, begin1 = 1'b0;
  logic [7:0] send_data1 = 8'h00;
  logic [7:0] spi_recv_data = 8'h00;
  logic       spi_end = 1'b0;
  logic [7:0] recv_data0, recv_data1, spi_send_data;
  logic       end0, end1, gnt0, gnt1, spi_begin, spi_ss, timeout_err;
  logic [1:0] cs_n;

  int n_chk = 0;
  int n_fail = 0;
  int mon_bad = 0;
  int end1_cnt = 0;
  logic mon_en = 1'b0;
  logic cnt_en = 1'b0;

  spi_bus_arbiter #(.GUARD_CYCLES(4), .TIMEOUT(100)) dut (
    .clk(clk), .RST(RST),
    .req0(req0), .lock0(lock0), .begin0(begin0), .send_data0(send_data0),
    .recv_data0(recv_data0), .end0(end0), .gnt0(gnt0),
    .req1(req1), .lock1(lock1), .begin1(begin1), .send_data1(send_data1),
    .recv_data1(recv_data1), .end1(end1), .gnt1(gnt1),
    .spi_begin(spi_begin), .spi_send_data(spi_send_data),
    .spi_recv_data(spi_recv_data), .spi_end(spi_end),
    .spi_ss(spi_ss), .cs_n(cs_n), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en && (cs_n !== 2'b01 || gnt1 !== 1'b1 || gnt0 !== 1'b0)) mon_bad++;
    if (cnt_en && end1 === 1'b1) end1_cnt++;
  end

  typedef struct {
    logic [1:0] rq, lk, bg;
    logic [7:0] sd0, sd1;
    logic       spe;
    logic [7:0] rd;
    int         rep;
    logic [1:0] gnt, cs;
    logic       sb;
    logic [7:0] ssd;
    logic [1:0] en;
    logic [7:0] r0, r1;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic [1:0] rq, input logic [1:0] lk, input logic [1:0] bg,
                              input logic [7:0] sd0, input logic [7:0] sd1, input logic spe,
                              input logic [7:0] rd, input int rep, input logic [1:0] gnt,
                              input logic [1:0] cs, input logic sb, input logic [7:0] ssd,
                              input logic [1:0] en, input logic [7:0] r0, input logic [7:0] r1);
    vec_t v;
    v.rq = rq; v.lk = lk; v.bg = bg; v.sd0 = sd0; v.sd1 = sd1; v.spe = spe; v.rd = rd;
    v.rep = rep; v.gnt = gnt; v.cs = cs; v.sb = sb; v.ssd = ssd; v.en = en; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    req0 = 1'b0; lock0 = 1'b0; begin0 = 1'b0; send_data0 = 8'h00;
    req1 = 1'b0; lock1 = 1'b0; begin1 = 1'b0; send_data1 = 8'h00;
    spi_end = 1'b0; spi_recv_data = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    RST = 1'b1;
  endtask

  function automatic logic [63:0] bundle();
    return 64'({gnt1, gnt0, cs_n, spi_ss, spi_begin, spi_send_data, end1, end0,
                recv_data0, recv_data1, timeout_err});
  endfunction

  initial begin
    int k;
    logic [7:0] b;

    // {req1,req0} {lock1,lock0} {begin1,begin0} sd0 sd1 spi_end rdata rep | gnt cs sb ssd {end1,end0} r0 r1
    tbl[0]  = mk(2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 1,  2'b01, 2'b10, 1'b0, 8'h00, 2'b00, 8'h00, 8'h00);
    tbl[1]  = mk(2'b01, 2'b00, 2'b10, 8'h00, 8'h55, 1'b0, 8'h00, 1,  2'b01, 2'b10, 1'b0, 8'h00, 2'b00, 8'h00, 8'h00);
    tbl[2]  = mk(2'b01, 2'b00, 2'b01, 8'h8F, 8'h00, 1'b0, 8'h00, 1,  2'b01, 2'b10, 1'b1, 8'h8F, 2'b00, 8'h00, 8'h00);
    tbl[3]  = mk(2'b01, 2'b00, 2'b01, 8'h11, 8'h00, 1'b0, 8'h00, 1,  2'b01, 2'b10, 1'b0, 8'h8F, 2'b00, 8'h00, 8'h00);
    tbl[4]  = mk(2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 14, 2'b01, 2'b10, 1'b0, 8'h8F, 2'b00, 8'h00, 8'h00);
    tbl[5]  = mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 8'hD3, 1,  2'b00, 2'b11, 1'b0, 8'h8F, 2'b01, 8'hD3, 8'h00);
    tbl[6]  = mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 4,  2'b00, 2'b11, 1'b0, 8'h8F, 2'b00, 8'hD3, 8'h00);
    tbl[7]  = mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 8'hAA, 1,  2'b00, 2'b11, 1'b0, 8'h8F, 2'b00, 8'hD3, 8'h00);
    tbl[8]  = mk(2'b11, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 1,  2'b10, 2'b01, 1'b0, 8'h8F, 2'b00, 8'hD3, 8'h00);
    tbl[9]  = mk(2'b11, 2'b00, 2'b10, 8'h00, 8'h3C, 1'b0, 8'h00, 1,  2'b10, 2'b01, 1'b1, 8'h3C, 2'b00, 8'hD3, 8'h00);
    tbl[10] = mk(2'b11, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 8'h5A, 1,  2'b00, 2'b11, 1'b0, 8'h3C, 2'b10, 8'hD3, 8'h5A);
    tbl[11] = mk(2'b11, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 4,  2'b00, 2'b11, 1'b0, 8'h3C, 2'b00, 8'hD3, 8'h5A);
    tbl[12] = mk(2'b11, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 1,  2'b01, 2'b10, 1'b0, 8'h3C, 2'b00, 8'hD3, 8'h5A);

    do_reset();
    chk("reset_state", bundle(), 64'({2'b00, 2'b11, 1'b1, 1'b0, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0}));

    // Single byte, non-owner strobe, spi_end in IDLE, then round-robin ties
    for (int i = 0; i < 13; i++) begin
      req0 = tbl[i].rq[0]; req1 = tbl[i].rq[1];
      lock0 = tbl[i].lk[0]; lock1 = tbl[i].lk[1];
      begin0 = tbl[i].bg[0]; begin1 = tbl[i].bg[1];
      send_data0 = tbl[i].sd0; send_data1 = tbl[i].sd1;
      spi_end = tbl[i].spe; spi_recv_data = tbl[i].rd;
      for (int r = 0; r < tbl[i].rep; r++) begin
        tick();
        chk($sformatf("vec%0d_cyc%0d", i, r), bundle(),
            64'({tbl[i].gnt, tbl[i].cs, &tbl[i].cs, tbl[i].sb, tbl[i].ssd, tbl[i].en,
                 tbl[i].r0, tbl[i].r1, 1'b0}));
      end
    end

    // Locked burst on requester 1 with requester 0 arriving mid-burst
    do_reset();
    req1 = 1'b1; lock1 = 1'b1;
    tick();
    chk("burst_grant", 64'({gnt1, gnt0, cs_n}), 64'({2'b10, 2'b01}));
    mon_en = 1'b1; cnt_en = 1'b1; end1_cnt = 0; mon_bad = 0;
    for (int i = 0; i < 7; i++) begin
      b = (i == 0) ? 8'hE8 : 8'(i);
      if (i == 3) req0 = 1'b1;
      begin1 = 1'b1; send_data1 = b;
      tick();
      begin1 = 1'b0;
      chk("burst_begin", 64'({spi_begin, spi_send_data}), 64'({1'b1, b}));
      tick();
      tick();
      if (i == 6) begin
        lock1 = 1'b0;
        mon_en = 1'b0;
      end
      spi_end = 1'b1; spi_recv_data = ~b;
      tick();
      spi_end = 1'b0;
      chk("burst_end", 64'({end1, recv_data1}), 64'({1'b1, ~b}));
    end
    chk("burst_cs_continuous", 64'(mon_bad), 64'd0);
    req1 = 1'b0;
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (gnt0 === 1'b1) begin
        k = c;
        break;
      end
    end
    cnt_en = 1'b0;
    chk("burst_req0_grant_delay", 64'(k), 64'd5);
    chk("burst_end1_count", 64'(end1_cnt), 64'd7);

    // Idle timeout in HOLD
    do_reset();
    req0 = 1'b1; lock0 = 1'b1;
    tick();
    begin0 = 1'b1; send_data0 = 8'hA5;
    tick();
    begin0 = 1'b0;
    tick();
    spi_end = 1'b1; spi_recv_data = 8'h3C;
    tick();
    spi_end = 1'b0;
    chk("to_end0", 64'({end0, recv_data0, gnt0, cs_n}), 64'({1'b1, 8'h3C, 1'b1, 2'b10}));
    k = 0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (timeout_err === 1'b1) begin
        k = c;
        break;
      end
    end
    chk("to_delay", 64'(k), 64'd100);
    chk("to_release", 64'({gnt1, gnt0, cs_n, spi_ss}), 64'({2'b00, 2'b11, 1'b1}));
    tick();
    chk("to_pulse_width", 64'(timeout_err), 64'd0);
    req0 = 1'b0; lock0 = 1'b0;

    // Asynchronous reset during XFER, then stray spi_end and a fresh tie
    do_reset();
    req0 = 1'b1;
    tick();
    begin0 = 1'b1; send_data0 = 8'h42;
    tick();
    begin0 = 1'b0;
    tick();
    chk("rst_pre", 64'({gnt0, cs_n}), 64'({1'b1, 2'b10}));
    #2 RST = 1'b0;
    #1 chk("rst_async", 64'({gnt1, gnt0, cs_n, spi_ss, spi_begin}), 64'({2'b00, 2'b11, 1'b1, 1'b0}));
    req0 = 1'b0;
    #2 RST = 1'b1;
    tick();
    spi_end = 1'b1; spi_recv_data = 8'h77;
    tick();
    spi_end = 1'b0;
    chk("rst_stray_end", 64'({end1, end0, recv_data0, gnt0}), 64'({2'b00, 8'h00, 1'b0}));
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk("rst_tie_grant", 64'({gnt1, gnt0, cs_n}), 64'({2'b01, 2'b10}));
    req0 = 1'b0; req1 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
